decode: RTL
===========

DECODE -- requirements
Module: decode

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: in_valid input 1, in_ready output 1  fetch→decode handshake.
REQ-004 SHALL have ports: in_pc input 64 (u64), in_instr input 32 (u32)  fetched PC and raw instruction.
REQ-005 SHALL have ports: ra1, ra2 output 5  regfile read addresses; rd1, rd2 input 64  regfile read data, same cycle.
REQ-006 SHALL have port: flush input 1  kill in-flight and incoming instruction.
REQ-007 SHALL have ports: out_valid output 1, out_ready input 1  decode→execute handshake.
REQ-008 SHALL have ports: out_pc 64, out_a 64, out_b 64, out_alufunc (alufunc_t), out_rd 5, out_regwrite 1, all outputs, registered.

Function
REQ-009 SHALL decode the RV64I subset: ADDI/XORI/ORI/ANDI (opcode 0010011, funct3 000/100/110/111), ADD/SUB/XOR/OR/AND (opcode 0110011, funct7 0000000/0100000 for ADD/SUB, funct3 000/100/110/111), LUI (opcode 0110111).
REQ-010 SHALL drive ra1=instr[19:15], ra2=instr[24:20] combinationally from in_instr.
REQ-011 SHALL set a=rd1 for OP/OP-IMM; b=rd2 for OP, sign-extended imm[11:0] to 64 bits for OP-IMM.
REQ-012 SHALL encode LUI as alufunc=NOP, b=sign-extend({instr[31:12],12'b0}) to 64 bits, a=0.
REQ-013 SHALL map ops to ALU_ADD/ALU_SUB/ALU_XOR/ALU_OR/ALU_AND; unsupported encodings produce alufunc=NOP, regwrite=0.
REQ-014 SHALL force out_regwrite=0 when rd field is x0.
REQ-015 SHALL drive in_ready = !out_valid || out_ready (single-entry output register, no bubble under continuous flow).
REQ-016 SHALL accept on in_valid && in_ready && !flush; accepted instruction appears on outputs next cycle, latency exactly 1.
REQ-017 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-018 SHALL clear out_valid when out_valid && out_ready and no new accept in that cycle.
REQ-019 SHALL, on flush, clear out_valid next cycle and discard any input presented that cycle; flush outranks simultaneous accept and stall.

Reset
REQ-020 SHALL on reset set out_valid=0, out_pc=0, out_a=0, out_b=0, out_alufunc=NOP, out_rd=0, out_regwrite=0, out_illegal=0 (if present).
REQ-021 SHALL ignore in_valid and flush during a reset cycle; reset mid-stall discards the held instruction.

Configuration
REQ-022 SHALL, when macro DECODE_ILLEGAL_EN is defined, add output out_illegal 1, registered with the other outputs, set to 1 for any encoding outside REQ-009 (instruction still passes as NOP, regwrite=0).
REQ-023 SHALL, without DECODE_ILLEGAL_EN, omit out_illegal; unsupported encodings silently become NOP with regwrite=0.

Structure
REQ-024 SHALL place opcode/funct3/funct7 constants and a decode_out_t struct (pc, a, b, alufunc, rd, regwrite) in package pipes beside alufunc_t; u64/u32 come from common.
REQ-025 SHALL split pure combinational instruction decoding into sub-module decoder; decode owns handshake and output register.

Verification
REQ-026 SHALL cover: reset, then instr 0x00500093 (addi x1,x0,5), rd1=0 -> next cycle out_valid=1, alufunc=ALU_ADD, a=0, b=5, rd=1, regwrite=1.
REQ-027 SHALL cover: 0x402081B3 (sub x3,x1,x2), rd1=10, rd2=3 -> ra1=1, ra2=2; next cycle alufunc=ALU_SUB, a=10, b=3, rd=3.
REQ-028 SHALL cover: 0xFFF00093 -> b=0xFFFFFFFFFFFFFFFF; 0x800002B7 (lui x5) -> alufunc=NOP, b=0xFFFFFFFF80000000.
REQ-029 SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs unchanged; out_ready=1 -> next instruction appears following cycle, none lost or duplicated.
REQ-030 SHALL cover: flush asserted with in_valid=1 and out_valid=1 -> next cycle out_valid=0, flushed input never appears.
REQ-031 SHALL cover: 0x00000013 with rd=x0 -> regwrite=0; 0x0000007F with DECODE_ILLEGAL_EN -> out_illegal=1, alufunc=NOP, regwrite=0.

Source files
------------

// File: rtl/common_pkg.sv
// Scalar types shared across the pipeline packages.
package common;
    typedef logic [63:0] u64;
    typedef logic [31:0] u32;
endpackage

// File: rtl/pipes_pkg.sv
// Decode-stage types: ALU function codes, RV64I field constants and the registered decode payload.
package pipes;
    import common::*;

    typedef enum logic [2:0] {
        NOP     = 3'd0,
        ALU_ADD = 3'd1,
        ALU_SUB = 3'd2,
        ALU_XOR = 3'd3,
        ALU_OR  = 3'd4,
        ALU_AND = 3'd5
    } alufunc_t;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        u64         pc;
        u64         a;
        u64         b;
        alufunc_t   alufunc;
        logic [4:0] rd;
        logic       regwrite;
    } decode_out_t;

    localparam decode_out_t DECODE_OUT_RESET = '{
        pc: '0, a: '0, b: '0, alufunc: NOP, rd: '0, regwrite: 1'b0
    };

    function automatic u64 immI(input u32 instr);
        return {{52{instr[31]}}, instr[31:20]};
    endfunction

    function automatic u64 immU(input u32 instr);
        return {{32{instr[31]}}, instr[31:12], 12'b0};
    endfunction
endpackage

// File: rtl/decode_decoder.sv
// Pure combinational RV64I-subset decoder; out_illegal support compiled in with DECODE_ILLEGAL_EN.
module decoder
    import common::*;
    import pipes::*;
(
    input  u32          instr_i,
    input  u64          pc_i,
    input  u64          rd1_i,
    input  u64          rd2_i,
`ifdef DECODE_ILLEGAL_EN
    output logic        illegal_o,
`endif
    output decode_out_t dec_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       legal;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    always_comb begin
        dec_o          = DECODE_OUT_RESET;
        dec_o.pc       = pc_i;
        dec_o.rd       = instr_i[11:7];
        legal          = 1'b0;

        unique case (opcode)
            OPC_OP_IMM: begin
                dec_o.a = rd1_i;
                dec_o.b = immI(instr_i);
                legal   = 1'b1;
                case (funct3)
                    F3_ADD:  dec_o.alufunc = ALU_ADD;
                    F3_XOR:  dec_o.alufunc = ALU_XOR;
                    F3_OR:   dec_o.alufunc = ALU_OR;
                    F3_AND:  dec_o.alufunc = ALU_AND;
                    default: legal         = 1'b0;
                endcase
            end
            OPC_OP: begin
                dec_o.a = rd1_i;
                dec_o.b = rd2_i;
                legal   = 1'b1;
                // SUB is the only funct7=0100000 form in the supported subset
                if (funct7 == F7_ALT && funct3 == F3_ADD) begin
                    dec_o.alufunc = ALU_SUB;
                end else if (funct7 == F7_BASE) begin
                    case (funct3)
                        F3_ADD:  dec_o.alufunc = ALU_ADD;
                        F3_XOR:  dec_o.alufunc = ALU_XOR;
                        F3_OR:   dec_o.alufunc = ALU_OR;
                        F3_AND:  dec_o.alufunc = ALU_AND;
                        default: legal         = 1'b0;
                    endcase
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_LUI: begin
                dec_o.b = immU(instr_i);
                legal   = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            dec_o.alufunc = NOP;
            dec_o.a       = '0;
            dec_o.b       = '0;
        end
        dec_o.regwrite = legal && (instr_i[11:7] != 5'd0);
    end

`ifdef DECODE_ILLEGAL_EN
    assign illegal_o = !legal;
`endif

endmodule

// File: rtl/decode.sv
// Decode stage: single-entry output register with valid/ready handshake and flush.
// Optional out_illegal flag is enabled by defining DECODE_ILLEGAL_EN.
module decode
    import common::*;
    import pipes::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  u64         in_pc,
    input  u32         in_instr,
    output logic [4:0] ra1,
    output logic [4:0] ra2,
    input  u64         rd1,
    input  u64         rd2,
    input  logic       flush,
    output logic       out_valid,
    input  logic       out_ready,
    output u64         out_pc,
    output u64         out_a,
    output u64         out_b,
    output alufunc_t   out_alufunc,
    output logic [4:0] out_rd,
`ifdef DECODE_ILLEGAL_EN
    output logic       out_illegal,
`endif
    output logic       out_regwrite
);

    decode_out_t decoded;
    decode_out_t data_q, data_d;
    logic        valid_q, valid_d;
    logic        accept;

    assign ra1 = in_instr[19:15];
    assign ra2 = in_instr[24:20];

`ifdef DECODE_ILLEGAL_EN
    logic decodedIllegal;
    logic illegal_q, illegal_d;

    decoder u_decoder (
        .instr_i   (in_instr),
        .pc_i      (in_pc),
        .rd1_i     (rd1),
        .rd2_i     (rd2),
        .illegal_o (decodedIllegal),
        .dec_o     (decoded)
    );
`else
    decoder u_decoder (
        .instr_i (in_instr),
        .pc_i    (in_pc),
        .rd1_i   (rd1),
        .rd2_i   (rd2),
        .dec_o   (decoded)
    );
`endif

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // Flush wins over accept and stall; data is left as-is when only valid drops
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
`ifdef DECODE_ILLEGAL_EN
        illegal_d = illegal_q;
`endif
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            data_d  = decoded;
`ifdef DECODE_ILLEGAL_EN
            illegal_d = decodedIllegal;
`endif
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= DECODE_OUT_RESET;
`ifdef DECODE_ILLEGAL_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
`ifdef DECODE_ILLEGAL_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    assign out_valid    = valid_q;
    assign out_pc       = data_q.pc;
    assign out_a        = data_q.a;
    assign out_b        = data_q.b;
    assign out_alufunc  = data_q.alufunc;
    assign out_rd       = data_q.rd;
    assign out_regwrite = data_q.regwrite;
`ifdef DECODE_ILLEGAL_EN
    assign out_illegal  = illegal_q;
`endif

endmodule
